// File: rtl/engine_rpm_model.sv
// Engine-speed model: saturating accel/brake/decay steps on a prescaled tick,
// plus rev-matching on gear change (rpm * ratio_new / ratio_old) using one
// multiply cycle and a bit-serial restoring divider.
module engine_rpm_model #(
    parameter int                     RPM_W       = 16,
    parameter int                     NUM_GEARS   = 6,
    parameter logic [8*NUM_GEARS-1:0] GEAR_RATIOS = 48'h0A0D10162038,
    parameter int                     TICK_DIV    = 5000000,
    parameter int                     DECAY_TICKS = 10,
    parameter int                     ACCEL_STEP  = 50,
    parameter int                     DECEL_STEP  = 100,
    parameter int                     DECAY_STEP  = 25,
    parameter int                     RPM_IDLE    = 800,
    parameter int                     RPM_MAX     = 8000,
    parameter int                     REDLINE     = 7000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       gear,
    input  logic             throttle,
    input  logic             brake,
    output logic [RPM_W-1:0] rpm,
    output logic             busy,
    output logic             shift_up,
    output logic             shift_down,
    output logic             redline,
    output logic             gear_err
);

    localparam int PROD_W = RPM_W + 8;
    localparam int CNT_W  = $clog2(PROD_W);
    localparam int PRE_W  = $clog2(TICK_DIV);
    localparam int DEC_W  = $clog2(DECAY_TICKS + 1);

    localparam logic [RPM_W:0] IDLE_X  = (RPM_W+1)'(RPM_IDLE);
    localparam logic [RPM_W:0] MAX_X   = (RPM_W+1)'(RPM_MAX);
    localparam logic [RPM_W:0] ACCEL_X = (RPM_W+1)'(ACCEL_STEP);
    localparam logic [RPM_W:0] DECEL_X = (RPM_W+1)'(DECEL_STEP);
    localparam logic [RPM_W:0] DECAY_X = (RPM_W+1)'(DECAY_STEP);

    typedef enum logic [1:0] {S_RUN, S_MUL, S_DIV, S_WRITE} state_t;

    state_t              state_reg, state_next;
    logic [PRE_W-1:0]    presc_reg;
    logic [RPM_W-1:0]    rpm_reg;
    logic [2:0]          gear_q_reg, gear_old_reg;
    logic [DEC_W-1:0]    decay_reg;
    logic                tick_pend_reg;
    logic [PROD_W-1:0]   quo_reg;
    logic [7:0]          rem_reg;
    logic [CNT_W-1:0]    div_cnt_reg;
    logic                busy_reg, shift_up_reg, shift_down_reg;

    logic                tick, gear_valid, gear_diff, start_match, decay_hit;
    logic [7:0]          ratio_tab [0:7];
    logic [7:0]          ratio_new, ratio_old;
    logic [RPM_W:0]      rpm_ext, rpm_up, rpm_dn, rpm_dy;
    logic [RPM_W-1:0]    rpm_step, rpm_quo;
    logic [PROD_W-1:0]   prod;
    logic [8:0]          rem_sh, rem_sub;
    logic [7:0]          rem_nx;
    logic                div_ge, rem_unused;

    // Unpack the ratio table; entry 0 (neutral) and gears beyond NUM_GEARS read as zero.
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_ratio
            if (gi >= 1 && gi <= NUM_GEARS) begin : g_used
                assign ratio_tab[gi] = GEAR_RATIOS[8*gi-1 -: 8];
            end else begin : g_none
                assign ratio_tab[gi] = 8'd0;
            end
        end
    endgenerate

    assign ratio_new = ratio_tab[gear_q_reg];
    assign ratio_old = ratio_tab[gear_old_reg];
    assign tick      = (presc_reg == PRE_W'(TICK_DIV - 1));
    assign decay_hit = (decay_reg == DEC_W'(DECAY_TICKS - 1));

    // Free-running prescaler; runs in every state so tick spacing never drifts.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)     presc_reg <= '0;
        else if (tick) presc_reg <= '0;
        else           presc_reg <= presc_reg + 1'b1;
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_reg <= S_RUN;
        else       state_reg <= state_next;
    end

    // Next state and gear-change decode; only RUN samples the gear input.
    always_comb begin
        state_next  = state_reg;
        gear_valid  = (gear <= 3'(NUM_GEARS));
        gear_diff   = gear_valid && (gear != gear_q_reg);
        start_match = 1'b0;
        case (state_reg)
            S_RUN: begin
                if (gear_diff && gear != 3'd0 && gear_q_reg != 3'd0) begin
                    start_match = 1'b1;
                    state_next  = S_MUL;
                end
            end
            S_MUL:   state_next = S_DIV;
            S_DIV:   if (div_cnt_reg == CNT_W'(PROD_W - 1)) state_next = S_WRITE;
            S_WRITE: state_next = S_RUN;
            default: state_next = S_RUN;
        endcase
    end

    // Per-tick rpm step, evaluated one bit wider so nothing wraps before saturation.
    always_comb begin
        rpm_ext  = {1'b0, rpm_reg};
        rpm_up   = rpm_ext + ACCEL_X;
        rpm_dn   = rpm_ext - DECEL_X;
        rpm_dy   = rpm_ext - DECAY_X;
        rpm_step = rpm_reg;
        if (brake)
            rpm_step = (rpm_dn[RPM_W] || rpm_dn < IDLE_X) ? RPM_W'(RPM_IDLE) : rpm_dn[RPM_W-1:0];
        else if (throttle)
            rpm_step = (rpm_up > MAX_X) ? RPM_W'(RPM_MAX) : rpm_up[RPM_W-1:0];
        else if (decay_hit)
            rpm_step = (rpm_dy[RPM_W] || rpm_dy < IDLE_X) ? RPM_W'(RPM_IDLE) : rpm_dy[RPM_W-1:0];
    end

    // Multiplier, one restoring-divide step and the clamp of the final quotient.
    always_comb begin
        prod       = PROD_W'(rpm_reg) * PROD_W'(ratio_new);
        rem_sh     = {rem_reg, quo_reg[PROD_W-1]};
        div_ge     = (rem_sh >= {1'b0, ratio_old});
        rem_sub    = rem_sh - {1'b0, ratio_old};
        rem_nx     = div_ge ? rem_sub[7:0] : rem_sh[7:0];
        // The remainder after a subtract is always below the divisor, so bit 8 is zero.
        rem_unused = rem_sub[8];
        if (quo_reg > PROD_W'(RPM_MAX))       rpm_quo = RPM_W'(RPM_MAX);
        else if (quo_reg < PROD_W'(RPM_IDLE)) rpm_quo = RPM_W'(RPM_IDLE);
        else                                  rpm_quo = quo_reg[RPM_W-1:0];
    end

    // Datapath: rpm stepping, gear commit, tick pending and the divider registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rpm_reg        <= RPM_W'(RPM_IDLE);
            gear_q_reg     <= 3'd0;
            gear_old_reg   <= 3'd0;
            decay_reg      <= '0;
            tick_pend_reg  <= 1'b0;
            quo_reg        <= '0;
            rem_reg        <= '0;
            div_cnt_reg    <= '0;
            busy_reg       <= 1'b0;
            shift_up_reg   <= 1'b0;
            shift_down_reg <= 1'b0;
        end else begin
            shift_up_reg   <= 1'b0;
            shift_down_reg <= 1'b0;
            case (state_reg)
                S_RUN: begin
                    if (gear_diff) begin
                        // Gear change has priority; a coincident tick waits one cycle.
                        gear_q_reg    <= gear;
                        tick_pend_reg <= tick_pend_reg | tick;
                        if (start_match) begin
                            gear_old_reg   <= gear_q_reg;
                            busy_reg       <= 1'b1;
                            shift_up_reg   <= (gear > gear_q_reg);
                            shift_down_reg <= (gear < gear_q_reg);
                        end
                    end else if (tick || tick_pend_reg) begin
                        tick_pend_reg <= 1'b0;
                        rpm_reg       <= rpm_step;
                        if (throttle || brake || decay_hit) decay_reg <= '0;
                        else                                decay_reg <= decay_reg + 1'b1;
                    end
                end
                S_MUL: begin
                    if (tick) tick_pend_reg <= 1'b1;
                    quo_reg     <= prod;
                    rem_reg     <= '0;
                    div_cnt_reg <= '0;
                end
                S_DIV: begin
                    if (tick) tick_pend_reg <= 1'b1;
                    quo_reg     <= {quo_reg[PROD_W-2:0], div_ge};
                    rem_reg     <= rem_nx;
                    div_cnt_reg <= div_cnt_reg + 1'b1;
                end
                S_WRITE: begin
                    if (tick) tick_pend_reg <= 1'b1;
                    rpm_reg  <= rpm_quo;
                    busy_reg <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign rpm        = rpm_reg;
    assign busy       = busy_reg;
    assign shift_up   = shift_up_reg;
    assign shift_down = shift_down_reg;
    assign redline    = (rpm_reg >= RPM_W'(REDLINE));
    assign gear_err   = ~gear_valid;

endmodule

// File: tb/tb_engine_rpm_model.sv
// Scoreboard bench for engine_rpm_model: a behavioural model predicts every
// clock's outputs, a monitor compares them, plus directed checks of the
// worked examples (rev-match results, saturation, decay, async reset).
module tb_engine_rpm_model;

    localparam int TD = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  gear = 3'd0;
    logic        throttle = 1'b0;
    logic        brake = 1'b0;
    logic [15:0] rpm;
    logic        busy, shift_up, shift_down, redline, gear_err;

    engine_rpm_model #(.TICK_DIV(TD)) dut (
        .clk(clk), .reset(reset), .gear(gear), .throttle(throttle), .brake(brake),
        .rpm(rpm), .busy(busy), .shift_up(shift_up), .shift_down(shift_down),
        .redline(redline), .gear_err(gear_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] rpm;
        logic        busy;
        logic        su;
        logic        sd;
        logic        red;
        logic        gerr;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // Gear ratios in sixteenths: 3.5, 2.0, 1.375, 1.0, 0.8125, 0.625.
    int ratio16[8] = '{0, 56, 32, 22, 16, 13, 10, 0};

    // Reference model state.
    int m_rpm, m_gear, m_decay, m_left, m_target, m_cyc;
    bit m_pend, m_su, m_sd;

    logic [2:0] d_gear = 3'd0;
    logic       d_thr = 1'b0;
    logic       d_brk = 1'b0;

    function automatic int clampi(int v);
        if (v > 8000) return 8000;
        if (v < 800)  return 800;
        return v;
    endfunction

    task automatic model_reset();
        m_rpm = 800; m_gear = 0; m_decay = 0; m_left = 0; m_target = 0;
        m_cyc = 0; m_pend = 0; m_su = 0; m_sd = 0;
    endtask

    // What happens at one clock edge given the inputs held during the cycle.
    task automatic model_edge(int g, bit t, bit b);
        bit tk;
        m_cyc++;
        tk   = (m_cyc % TD) == 0;
        m_su = 0;
        m_sd = 0;
        if (m_left > 0) begin
            if (tk) m_pend = 1;
            m_left--;
            if (m_left == 0) m_rpm = m_target;
        end else if (g <= 6 && g != m_gear) begin
            if (tk) m_pend = 1;
            if (m_gear != 0 && g != 0) begin
                m_su     = g > m_gear;
                m_sd     = g < m_gear;
                m_target = clampi(m_rpm * ratio16[g] / ratio16[m_gear]);
                m_left   = 26;
            end
            m_gear = g;
        end else if (tk || m_pend) begin
            m_pend = 0;
            if (b) begin
                m_decay = 0;
                m_rpm = (m_rpm - 100 < 800) ? 800 : m_rpm - 100;
            end else if (t) begin
                m_decay = 0;
                m_rpm = (m_rpm + 50 > 8000) ? 8000 : m_rpm + 50;
            end else begin
                m_decay++;
                if (m_decay == 10) begin
                    m_decay = 0;
                    m_rpm = (m_rpm - 25 < 800) ? 800 : m_rpm - 25;
                end
            end
        end
    endtask

    task automatic check(string name, int act, int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // One clock: drive inputs at the falling edge, predict, queue the prediction.
    task automatic cycle();
        exp_t e;
        gear = d_gear; throttle = d_thr; brake = d_brk;
        model_edge(int'(d_gear), d_thr, d_brk);
        e.rpm  = 16'(m_rpm);
        e.busy = (m_left > 0);
        e.su   = m_su;
        e.sd   = m_sd;
        e.red  = (m_rpm >= 7000);
        e.gerr = (d_gear > 3'd6);
        sb.push_back(e);
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        check("reset_rpm", int'(rpm), 800);
        check("reset_busy", int'(busy), 0);
        check("reset_shift_up", int'(shift_up), 0);
        check("reset_shift_down", int'(shift_down), 0);
        model_reset();
        sb.delete();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic run_until(int target);
        bit hit = 0;
        for (int i = 0; i < 4000 && !hit; i++) begin
            cycle();
            if (m_rpm == target) hit = 1;
        end
        if (!hit) begin
            checks++; errors++;
            $display("FAIL run_until: got %0d, expected %0d", m_rpm, target);
        end
    endtask

    task automatic run_ticks(int n);
        for (int i = 0; i < n * TD; i++) cycle();
    endtask

    task automatic wait_match();
        cycle();
        for (int i = 0; i < 60 && m_left != 0; i++) cycle();
    endtask

    // Monitor: compare every post-edge output sample against the queued prediction.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                checks++;
                if (rpm !== e.rpm || busy !== e.busy || shift_up !== e.su ||
                    shift_down !== e.sd || redline !== e.red || gear_err !== e.gerr) begin
                    errors++;
                    $display("FAIL scoreboard t=%0t: got rpm=%0d busy=%b up=%b dn=%b red=%b gerr=%b, expected rpm=%0d busy=%b up=%b dn=%b red=%b gerr=%b",
                             $time, rpm, busy, shift_up, shift_down, redline, gear_err,
                             e.rpm, e.busy, e.su, e.sd, e.red, e.gerr);
                end
            end
        end
    end

    initial begin
        #2000000;
        errors++;
        $display("FAIL watchdog: got no completion, expected finish before time limit");
        $display("Result: errors=%0d of %0d checks", errors, checks + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk);
        do_reset();

        // Upshift 2 -> 3 at 4000: 4000*22/32 = 2750.
        d_gear = 3'd2; d_thr = 1'b1;
        run_until(4000);
        d_thr = 1'b0; d_gear = 3'd3;
        wait_match();
        check("upshift_2to3_rpm", int'(rpm), 2750);

        // Downshift 3 -> 2 at 3000: 3000*32/22 = 4363.
        d_thr = 1'b1;
        run_until(3000);
        d_thr = 1'b0; d_gear = 3'd2;
        wait_match();
        check("downshift_3to2_rpm", int'(rpm), 4363);

        // Saturation at the ceiling.
        d_thr = 1'b1;
        run_until(8000);
        run_ticks(20);
        check("saturate_rpm", int'(rpm), 8000);
        check("saturate_redline", int'(redline), 1);

        // Downshift 2 -> 1 at 5000: 8750 clamps to 8000.
        d_thr = 1'b0; d_brk = 1'b1;
        run_until(5000);
        d_brk = 1'b0; d_gear = 3'd1;
        wait_match();
        check("downshift_clamp_rpm", int'(rpm), 8000);
        check("downshift_clamp_redline", int'(redline), 1);

        // Brake wins over throttle, floor at idle.
        d_brk = 1'b1;
        run_until(1000);
        d_thr = 1'b1;
        run_ticks(1);
        check("brake_wins_1", int'(rpm), 900);
        run_ticks(1);
        check("brake_wins_2", int'(rpm), 800);
        run_ticks(3);
        check("brake_floor", int'(rpm), 800);

        // Coasting: one decay step every tenth tick.
        d_brk = 1'b0; d_thr = 1'b1;
        run_until(2000);
        d_thr = 1'b0;
        run_ticks(9);
        check("coast_9_ticks", int'(rpm), 2000);
        run_ticks(1);
        check("coast_10_ticks", int'(rpm), 1975);

        // Out-of-range gear is ignored.
        d_gear = 3'd7;
        run_ticks(2);
        check("gear7_err", int'(gear_err), 1);
        check("gear7_no_match", int'(busy), 0);
        d_gear = 3'd1;
        run_ticks(1);
        check("gear_back_no_match", int'(busy), 0);

        // Ticks during a match collapse into one step right after it.
        do_reset();
        d_gear = 3'd1; d_thr = 1'b1;
        run_until(1600);
        d_gear = 3'd2;
        wait_match();
        check("pend_match_rpm", int'(rpm), 914);
        cycle();
        check("pend_single_step", int'(rpm), 964);

        // Reset in the middle of the divide.
        d_thr = 1'b0; d_gear = 3'd3;
        for (int i = 0; i < 10; i++) cycle();
        do_reset();

        // Randomised traffic.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 1999) == 0) do_reset();
            if ($urandom_range(0, 39) == 0) d_gear = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 15) == 0) d_thr = ~d_thr;
            if ($urandom_range(0, 23) == 0) d_brk = ~d_brk;
            cycle();
        end

        check("scoreboard_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
